// File: rtl/id_decode_pipe.sv
// rtl/id_decode_pipe.sv - RV32 decode stage: register file, field/immediate decode, one output register
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       drop held and incoming instruction
//   in_valid/in_ready           fetch handshake; in_instr, in_pc instruction and its PC
//   wb_wen/wb_waddr/wb_wdata    register file write port
//   out_valid/out_ready         execute handshake
//   out_pc, out_src1, out_src2  registered PC and source operands
//   out_imm                     sign-extended immediate
//   out_rd, out_funct3, out_f7b5 destination and function fields
//   out_type                    instruction class (15 = illegal)
//   out_rd_wen, out_illegal     writes a non-zero rd / illegal encoding
module id_decode_pipe #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int WB_BYPASS = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_wen,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_imm,
    output logic [AW-1:0]   out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_f7b5,
    output logic [3:0]      out_type,
    output logic            out_rd_wen,
    output logic            out_illegal
);

    typedef enum logic [3:0] {
        T_OP     = 4'd0,
        T_OPIMM  = 4'd1,
        T_LOAD   = 4'd2,
        T_STORE  = 4'd3,
        T_BRANCH = 4'd4,
        T_JAL    = 4'd5,
        T_JALR   = 4'd6,
        T_LUI    = 4'd7,
        T_AUIPC  = 4'd8,
        T_ILL    = 4'd15
    } itype_t;

    // Register file; entry 0 exists but is never written and never read.
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wen && wb_waddr != '0) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    // Only the low AW bits of each register field address the file.
    logic [AW-1:0] rs1, rs2, rd;
    assign rs1 = in_instr[15 +: AW];
    assign rs2 = in_instr[20 +: AW];
    assign rd  = in_instr[7 +: AW];

    logic [XLEN-1:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = '0;
        if (rs1 != '0) begin
            if (WB_BYPASS != 0 && wb_wen && wb_waddr == rs1) begin
                rs1_val = wb_wdata;
            end else begin
                rs1_val = regs[rs1];
            end
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != '0) begin
            if (WB_BYPASS != 0 && wb_wen && wb_waddr == rs2) begin
                rs2_val = wb_wdata;
            end else begin
                rs2_val = regs[rs2];
            end
        end
    end

    itype_t          dec_type;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic            dec_rd_wen;
    logic            uses_rs2;

    always_comb begin
        dec_type = T_ILL;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:2])
                5'b01100: dec_type = T_OP;
                5'b00100: dec_type = T_OPIMM;
                5'b00000: dec_type = T_LOAD;
                5'b01000: dec_type = T_STORE;
                5'b11000: dec_type = T_BRANCH;
                5'b11011: dec_type = T_JAL;
                5'b11001: dec_type = T_JALR;
                5'b01101: dec_type = T_LUI;
                5'b00101: dec_type = T_AUIPC;
                default:  dec_type = T_ILL;
            endcase
        end
    end

    always_comb begin
        imm32 = '0;
        case (dec_type)
            T_OPIMM, T_LOAD, T_JALR:
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            T_STORE:
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            T_BRANCH:
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            T_JAL:
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            T_LUI, T_AUIPC:
                imm32 = {in_instr[31:12], 12'h000};
            default:
                imm32 = '0;
        endcase
    end

    // Widen to XLEN by sign extension of bit 31.
    assign imm_ext = XLEN'($signed(imm32));

    always_comb begin
        dec_rd_wen = 1'b0;
        case (dec_type)
            T_OP, T_OPIMM, T_LOAD, T_JAL, T_JALR, T_LUI, T_AUIPC:
                dec_rd_wen = (rd != '0);
            default:
                dec_rd_wen = 1'b0;
        endcase
    end

    assign uses_rs2 = (dec_type == T_OP) || (dec_type == T_STORE) || (dec_type == T_BRANCH);

    // A load in the output register cannot forward its data yet, so a
    // dependent consumer waits one cycle behind a bubble.
    logic stall;
    assign stall = out_valid && (out_type == T_LOAD) && (out_rd != '0) && in_valid &&
                   ((rs1 == out_rd) || (uses_rs2 && (rs2 == out_rd)));

    assign in_ready = (!out_valid || out_ready) && !stall && !flush;

    logic accept;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_src1    <= '0;
            out_src2    <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_funct3  <= '0;
            out_f7b5    <= 1'b0;
            out_type    <= '0;
            out_rd_wen  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_src1    <= rs1_val;
            out_src2    <= rs2_val;
            out_imm     <= imm_ext;
            out_rd      <= rd;
            out_funct3  <= in_instr[14:12];
            out_f7b5    <= in_instr[30];
            out_type    <= dec_type;
            out_rd_wen  <= dec_rd_wen;
            out_illegal <= (dec_type == T_ILL);
        end else if (out_ready) begin
            // Drained with nothing new (includes the load-use bubble).
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_decode_pipe.md
ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/register width (>=32).
REQ-002 SHALL have parameter NREG, default 32, architectural register count (power of 2, <=32); AW = log2(NREG).
REQ-003 SHALL have parameter WB_BYPASS, default 1, 1 = same-cycle writeback-to-read bypass enabled.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous discard of held and incoming instruction.
REQ-007 in_valid  in  1  fetch presents instruction; in_ready  out  1  decode accepts.
REQ-008 in_instr  in  32  raw instruction; in_pc  in  XLEN  its PC.
REQ-009 wb_wen  in  1, wb_waddr  in  AW, wb_wdata  in  XLEN  writeback port.
REQ-010 out_valid  out  1; out_ready  in  1  execute accepts.
REQ-011 out_pc, out_src1, out_src2, out_imm  out  XLEN  registered operands, sign-extended immediate.
REQ-012 out_rd  out  AW; out_funct3  out  3; out_f7b5  out  1 (instr[30]).
REQ-013 out_type  out  4: 0 OP,1 OP-IMM,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI,8 AUIPC,15 illegal.
REQ-014 out_rd_wen  out  1  instruction writes rd and rd!=0; out_illegal  out  1.

Function
REQ-015 SHALL contain NREG x XLEN register file; reg 0 reads 0 always, writes to 0 ignored.
REQ-016 Register write on rising edge when wb_wen; rs1/rs2 read combinationally in decode cycle.
REQ-017 WB_BYPASS=1: read address == wb_waddr, wb_wen=1, addr!=0 -> read returns wb_wdata same cycle; WB_BYPASS=0 -> old value.
REQ-018 Fields: rs1=instr[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12]; upper address bits ignored when NREG<32.
REQ-019 Immediates sign-extended from instr[31] to XLEN: I=[31:20]; S={[31:25],[11:7]}; B={[31],[7],[30:25],[11:8],0}; U={[31:12],12'b0}; J={[31],[19:12],[20],[30:21],0}; OP/illegal imm=0.
REQ-020 Opcode not in REQ-013 set, or instr[1:0]!=2'b11 -> out_type=15, out_illegal=1, out_rd_wen=0; still handed to execute.
REQ-021 out_rd_wen=1 only for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC with rd!=0.
REQ-022 Output is one pipeline register; accept = in_valid & in_ready; latency in-accept -> out_valid = 1 cycle.
REQ-023 in_ready = (!out_valid | out_ready) & !stall & !flush.
REQ-024 Once out_valid=1, all out_* SHALL hold stable until out_ready=1 or flush.
REQ-025 Load-use stall: stall=1 when out_valid & out_type==LOAD & out_rd!=0 & in_valid & (rs1==out_rd, or rs2==out_rd for OP/STORE/BRANCH).
REQ-026 During stall with out_ready=1: out_valid<=0 next cycle (one bubble), input held by fetch; stall with out_ready=0: output held.
REQ-027 Each accepted instruction SHALL appear at output exactly once; no duplication, no loss except flush.
REQ-028 flush=1: out_valid<=0 next cycle, in_ready=0, register file writes still performed; flush beats stall and accept.
REQ-029 Simultaneous out_ready and accept: new instruction replaces old in same edge (full throughput, 1/cycle).
REQ-030 Forwarding from EX/MEM results is outside this block.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear out_valid, all out_* to 0, and all registers to 0.
REQ-032 Deassertion synchronous to clk; first accept possible on first edge after rst_n=1; in_ready=1 during reset release cycle when in_valid irrelevant.
REQ-033 Reset mid-transaction SHALL drop held instruction; no out_valid pulse after release until new accept.

Verification
REQ-034 Write x5=0x1234 via wb, then in_instr=addi x6,x5,-1 (0xFFF28313) -> next cycle out_valid=1, out_src1=0x1234, out_imm=0xFFFFFFFF, out_type=1, out_rd=6, out_rd_wen=1.
REQ-035 Same cycle wb_wen x7=0xA5A5A5A5 and decode add x1,x7,x0 -> out_src1=0xA5A5A5A5 (WB_BYPASS=1), 0 (WB_BYPASS=0); x0 write of 0xFF -> x0 reads 0.
REQ-036 lw x3,0(x2) accepted, then add x4,x3,x1 presented, out_ready=1 -> in_ready=0 one cycle, one bubble cycle (out_valid=0), then add issued; x0 dest load -> no stall.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> back-to-back 1/cycle throughput.
REQ-038 Instr 0x00000000 -> out_illegal=1, out_type=15; jal x1,-4 (0xFFDFF0EF) -> out_imm=0xFFFFFFFC; beq imm -2 -> 0xFFFFFFFE.
REQ-039 flush with held valid instruction -> out_valid=0 next cycle; rst_n low mid-stall -> all outputs 0 immediately, registers 0.
